// File: rtl/uart_bus_arbiter.sv
// Two-master arbiter/sequencer for the fake UART register bus.
// Alternates grants on ties and drives one write strobe or a timed read per transfer.
module uart_bus_arbiter #(
    parameter int RD_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        n_reset_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [5:0]  m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_data_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [5:0]  m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_data_o,
    output logic [5:0]  addr_o,
    output logic [31:0] data_o,
    output logic        write_o,
    output logic        read_o,
    input  logic [31:0] data_i,
    output logic        owner_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [31:0] m0_rd_q, m0_rd_d;
    logic [31:0] m1_rd_q, m1_rd_d;
    logic        sel_s;

    // Pick the master to grant: a tie goes to whoever was not served last.
    always_comb begin
        if (m0_req_i && m1_req_i) begin
            sel_s = ~last_q;
        end else if (m1_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Next-state and registered-output computation for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        write_d  = 1'b0;
        read_d   = 1'b0;
        m0_ack_d = 1'b0;
        m1_ack_d = 1'b0;
        m0_rd_d  = m0_rd_q;
        m1_rd_d  = m1_rd_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    addr_d  = sel_s ? m1_addr_i : m0_addr_i;
                    data_d  = sel_s ? m1_data_i : m0_data_i;
                    we_d    = sel_s ? m1_we_i : m0_we_i;
                    owner_d = sel_s;
                    // Strobes are set on the grant edge so they are high during ISSUE.
                    write_d = sel_s ? m1_we_i : m0_we_i;
                    read_d  = sel_s ? ~m1_we_i : ~m0_we_i;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    state_d  = S_ACK;
                end else begin
                    cnt_d   = RD_LAT_C;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (owner_q) begin
                        m1_rd_d = data_i;
                    end else begin
                        m0_rd_d = data_i;
                    end
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    state_d  = S_ACK;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_ACK: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q  <= S_IDLE;
            addr_q   <= 6'd0;
            data_q   <= 32'd0;
            we_q     <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 3'd0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_rd_q  <= 32'd0;
            m1_rd_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            read_q   <= read_d;
            m0_ack_q <= m0_ack_d;
            m1_ack_q <= m1_ack_d;
            m0_rd_q  <= m0_rd_d;
            m1_rd_q  <= m1_rd_d;
        end
    end

    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign write_o   = write_q;
    assign read_o    = read_q;
    assign owner_o   = owner_q;
    assign m0_ack_o  = m0_ack_q;
    assign m1_ack_o  = m1_ack_q;
    assign m0_data_o = m0_rd_q;
    assign m1_data_o = m1_rd_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: a table of single-master transfers
// plus hand-written sequences for fairness, mid-transfer drop and async reset.
module tb_uart_bus_arbiter;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [5:0]  m0_addr = 6'd0;
    logic [31:0] m0_data = 32'd0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [5:0]  m1_addr = 6'd0;
    logic [31:0] m1_data = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic        m0_ack, m1_ack, write_o, read_o, owner_o, busy_o;
    logic [31:0] m0_rdata, m1_rdata, data_o;
    logic [5:0]  addr_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_m0_rd = 32'd0;
    logic [31:0] exp_m1_rd = 32'd0;

    typedef struct {
        logic        mst;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] din;
        int          ack_cyc;
        logic [31:0] exp_rd;
    } xfer_t;

    xfer_t vecs [6];

    uart_bus_arbiter #(.RD_LATENCY(RDL)) dut (
        .clk_i(clk), .n_reset_i(n_reset),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_data),
        .m0_ack_o(m0_ack), .m0_data_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_data),
        .m1_ack_o(m1_ack), .m1_data_o(m1_rdata),
        .addr_o(addr_o), .data_o(data_o), .write_o(write_o), .read_o(read_o),
        .data_i(data_i), .owner_o(owner_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_strobes"}, 32'({write_o, read_o}), 32'd0);
        chk({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'd0);
        chk({tag, "_owner"}, 32'(owner_o), 32'd0);
        chk({tag, "_addr"}, 32'(addr_o), 32'd0);
        chk({tag, "_data_o"}, data_o, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    endtask

    task automatic run_xfer(input xfer_t v);
        bit done;
        if (v.mst) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_data = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_data = v.wdata;
        end
        data_i = v.din;
        done = 1'b0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            chk("tbl_write_o", 32'(write_o), 32'(c == 1 && v.we));
            chk("tbl_read_o", 32'(read_o), 32'(c == 1 && !v.we));
            chk("tbl_ack_owner", 32'(v.mst ? m1_ack : m0_ack), 32'(c == v.ack_cyc));
            chk("tbl_ack_other", 32'(v.mst ? m0_ack : m1_ack), 32'd0);
            if (c == 1) begin
                chk("tbl_addr_o", 32'(addr_o), 32'(v.addr));
                chk("tbl_data_o", data_o, v.wdata);
                chk("tbl_owner_o", 32'(owner_o), 32'(v.mst));
                chk("tbl_busy", 32'(busy_o), 32'd1);
            end
            if (c == v.ack_cyc) begin
                if (!v.we && v.mst) exp_m1_rd = v.exp_rd;
                if (!v.we && !v.mst) exp_m0_rd = v.exp_rd;
                chk("tbl_m0_rdata", m0_rdata, exp_m0_rd);
                chk("tbl_m1_rdata", m1_rdata, exp_m1_rd);
                m0_req = 1'b0;
                m1_req = 1'b0;
                done = 1'b1;
            end
        end
        @(negedge clk);
        chk("tbl_idle_busy", 32'(busy_o), 32'd0);
        chk("tbl_idle_acks", 32'({m0_ack, m1_ack}), 32'd0);
    endtask

    initial begin
        int n_acks;
        int last_c;
        int exp_m;

        vecs[0] = '{mst: 1'b0, we: 1'b1, addr: 6'd2,  wdata: 32'h0000_0001, din: 32'h0,         ack_cyc: 2, exp_rd: 32'h0};
        vecs[1] = '{mst: 1'b1, we: 1'b0, addr: 6'd0,  wdata: 32'h0000_0000, din: 32'h0000_005A, ack_cyc: 4, exp_rd: 32'h0000_005A};
        vecs[2] = '{mst: 1'b0, we: 1'b0, addr: 6'd63, wdata: 32'h1111_2222, din: 32'hDEAD_BEEF, ack_cyc: 4, exp_rd: 32'hDEAD_BEEF};
        vecs[3] = '{mst: 1'b1, we: 1'b1, addr: 6'd63, wdata: 32'hFFFF_FFFF, din: 32'h0BAD_0BAD, ack_cyc: 2, exp_rd: 32'h0};
        vecs[4] = '{mst: 1'b0, we: 1'b1, addr: 6'd0,  wdata: 32'h0000_0000, din: 32'h5555_5555, ack_cyc: 2, exp_rd: 32'h0};
        vecs[5] = '{mst: 1'b1, we: 1'b0, addr: 6'd5,  wdata: 32'hAAAA_AAAA, din: 32'h0000_0000, ack_cyc: 4, exp_rd: 32'h0000_0000};

        // Reset, release, and stay quiet for 10 cycles.
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        n_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_all_zero("quiet");
        end

        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

        // Both masters issue writes continuously: grants alternate starting with m0.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd10; m0_data = 32'h0000_00A0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd20; m1_data = 32'h0000_00B0;
        n_acks = 0;
        last_c = 0;
        for (int c = 1; c <= 40 && n_acks < 6; c++) begin
            @(negedge clk);
            if (write_o) chk("fair_addr", 32'(addr_o), owner_o ? 32'd20 : 32'd10);
            if (m0_ack || m1_ack) begin
                exp_m = n_acks % 2;
                chk("fair_ack_order", 32'(m1_ack), 32'(exp_m));
                chk("fair_both_ack", 32'(m0_ack & m1_ack), 32'd0);
                chk("fair_owner_o", 32'(owner_o), 32'(exp_m));
                if (n_acks > 0) chk("fair_gap", 32'(c - last_c), 32'd3);
                last_c = c;
                n_acks++;
                if (n_acks == 6) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        chk("fair_count", 32'(n_acks), 32'd6);
        @(negedge clk);
        chk("fair_idle", 32'(busy_o), 32'd0);

        // m0 read drops req during RD_WAIT; m1 write arrives and is served next.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd7;
        data_i = 32'h1234_5678;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("drop_m0_ack", 32'(m0_ack), 32'(c == 4));
            chk("drop_m1_ack", 32'(m1_ack), 32'(c == 7));
            case (c)
                1: begin
                    chk("drop_read_o", 32'(read_o), 32'd1);
                    chk("drop_owner0", 32'(owner_o), 32'd0);
                    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd3; m1_data = 32'h0000_0033;
                end
                2: begin
                    chk("drop_busy", 32'(busy_o), 32'd1);
                    m0_req = 1'b0;
                end
                4: chk("drop_m0_rdata", m0_rdata, 32'h1234_5678);
                5: chk("drop_idle", 32'(busy_o), 32'd0);
                6: begin
                    chk("drop_write_o", 32'(write_o), 32'd1);
                    chk("drop_owner1", 32'(owner_o), 32'd1);
                    chk("drop_addr", 32'(addr_o), 32'd3);
                end
                7: m1_req = 1'b0;
                default: ;
            endcase
        end
        chk("drop_m1_rdata_kept", m1_rdata, exp_m1_rd);

        // Asynchronous reset during RD_WAIT abandons the read with no ack.
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd9;
        data_i = 32'h0000_CAFE;
        @(negedge clk);
        chk("arst_read_o", 32'(read_o), 32'd1);
        @(negedge clk);
        chk("arst_busy_before", 32'(busy_o), 32'd1);
        #2 n_reset = 1'b0;
        #1 chk_all_zero("arst");
        m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
        end
        n_reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd1; m0_data = 32'h0000_0101;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd2; m1_data = 32'h0000_0202;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("post_m0_ack", 32'(m0_ack), 32'(c == 2));
            chk("post_m1_ack", 32'(m1_ack), 32'(c == 5));
            if (c == 1) begin
                chk("post_owner0", 32'(owner_o), 32'd0);
                chk("post_addr0", 32'(addr_o), 32'd1);
                chk("post_write0", 32'(write_o), 32'd1);
            end
            if (c == 2) m0_req = 1'b0;
            if (c == 4) chk("post_owner1", 32'(owner_o), 32'd1);
            if (c == 5) m1_req = 1'b0;
        end
        @(negedge clk);
        chk("post_idle", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
